// File: rtl/controlador_minmax_pkg.sv
// Shared definitions for the min/max reduction sequencer: FSM state encoding
// and the default width of the length/index fields.
package controlador_minmax_pkg;

  localparam int LARGURA_LEN_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECEBE  = 3'd1,
    ST_CMP_MAX = 3'd2,
    ST_CMP_MIN = 3'd3,
    ST_FIM     = 3'd4
  } estado_t;

endpackage

// File: rtl/comparador_8bits.sv
// Unsigned 8-bit magnitude comparator, purely combinational.
// Exactly one of the three flags is high for any pair of known inputs.
module comparador_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       a_gt_b,
  output logic       a_eq_b,
  output logic       a_lt_b
);

  assign a_gt_b = (a > b);
  assign a_eq_b = (a == b);
  assign a_lt_b = (a < b);

endmodule

// File: rtl/controlador_minmax.sv
// Scans a stream of unsigned bytes and tracks the maximum and minimum values
// with the index of their first occurrence, sharing one comparator over time.
module controlador_minmax
  import controlador_minmax_pkg::*;
#(
  parameter int LARGURA_LEN = LARGURA_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LARGURA_LEN-1:0] len,
  input  logic [7:0]             dado,
  input  logic                   dado_valid,
  output logic                   dado_ready,
  output logic [7:0]             max_out,
  output logic [7:0]             min_out,
  output logic [LARGURA_LEN-1:0] idx_max,
  output logic [LARGURA_LEN-1:0] idx_min,
  output logic                   busy,
  output logic                   done,
  output logic                   vazio
);

  localparam logic [LARGURA_LEN-1:0] UM   = LARGURA_LEN'(1);
  localparam logic [LARGURA_LEN-1:0] ZERO = '0;

  estado_t                state, state_next;
  logic [LARGURA_LEN-1:0] rem, idx;
  logic [7:0]             dado_reg;
  logic [7:0]             cmp_b;
  logic                   a_gt_b, a_eq_b, a_lt_b;
  logic                   transfer;

  // The single comparator always sees the latched operand; only b is muxed.
  assign cmp_b = (state == ST_CMP_MAX) ? max_out : min_out;

  comparador_8bits u_cmp (
    .a      (dado_reg),
    .b      (cmp_b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  assign transfer = dado_valid & dado_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so that no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    dado_ready = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = (len == ZERO) ? ST_FIM : ST_RECEBE;
      end
      ST_RECEBE: begin
        dado_ready = 1'b1;
        if (transfer) begin
          if (idx == ZERO) state_next = (rem == UM) ? ST_FIM : ST_RECEBE;
          else             state_next = ST_CMP_MAX;
        end
      end
      ST_CMP_MAX: state_next = ST_CMP_MIN;
      ST_CMP_MIN: state_next = (rem == UM) ? ST_FIM : ST_RECEBE;
      ST_FIM: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      idx      <= '0;
      dado_reg <= '0;
      max_out  <= '0;
      min_out  <= '0;
      idx_max  <= '0;
      idx_min  <= '0;
      vazio    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == ZERO) begin
              vazio <= 1'b1;
            end else begin
              rem   <= len;
              idx   <= '0;
              vazio <= 1'b0;
            end
          end
        end
        ST_RECEBE: begin
          if (transfer) begin
            dado_reg <= dado;
            // The first operand seeds both extremes without a comparison.
            if (idx == ZERO) begin
              max_out <= dado;
              min_out <= dado;
              idx_max <= '0;
              idx_min <= '0;
              idx     <= idx + UM;
              rem     <= rem - UM;
            end
          end
        end
        ST_CMP_MAX: begin
          if (a_gt_b) begin
            max_out <= dado_reg;
            idx_max <= idx;
          end
        end
        ST_CMP_MIN: begin
          if (a_lt_b) begin
            min_out <= dado_reg;
            idx_min <= idx;
          end
          idx <= idx + UM;
          rem <= rem - UM;
        end
        default: ;
      endcase
    end
  end

endmodule
